// File: rtl/control_unit.sv
// control_unit: main decoder plus ALU decoder for the Phase1 datapath.
// Decodes Opcode (and Func for R-type) into ALU/register-file controls.
// All outputs are registered: one cycle from instruction fields to controls.
// Optional feature macro: CONTROLUNIT_EXT_OPS_EN enables sub, nor, slt and slti.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [3:0] ALUControl
);

    // ALU operation encodings
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011;
`ifdef CONTROLUNIT_EXT_OPS_EN
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;
`endif

    // Opcodes
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
`ifdef CONTROLUNIT_EXT_OPS_EN
    localparam logic [5:0] OpSlti  = 6'b001010;
`endif

    // R-type function codes
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
`ifdef CONTROLUNIT_EXT_OPS_EN
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnNor = 6'b100111;
    localparam logic [5:0] FnSlt = 6'b101010;
`endif

    logic       alu_src_d,   alu_src_q;
    logic       reg_dst_d,   reg_dst_q;
    logic       reg_write_d, reg_write_q;
    logic [3:0] alu_ctrl_d,  alu_ctrl_q;

    // Combinational decode; anything unrecognised falls back to a harmless no-write
    always_comb begin
        alu_src_d   = 1'b0;
        reg_dst_d   = 1'b0;
        reg_write_d = 1'b0;
        alu_ctrl_d  = AluAnd;
        unique case (Opcode)
            OpRType: begin
                // Only commit the R-type controls when Func is a known operation
                unique case (Func)
                    FnAdd: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluAdd; end
                    FnAnd: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluAnd; end
                    FnOr:  begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluOr;  end
                    FnXor: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluXor; end
`ifdef CONTROLUNIT_EXT_OPS_EN
                    FnSub: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluSub; end
                    FnNor: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluNor; end
                    FnSlt: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluSlt; end
`endif
                    default: ;
                endcase
            end
            OpAddi: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluAdd; end
            OpAndi: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluAnd; end
            OpOri:  begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluOr;  end
            OpXori: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluXor; end
`ifdef CONTROLUNIT_EXT_OPS_EN
            OpSlti: begin alu_src_d = 1'b1; reg_write_d = 1'b1; alu_ctrl_d = AluSlt; end
`endif
            default: ;
        endcase
    end

    // Output register; reset overrides the decode
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src_q   <= 1'b0;
            reg_dst_q   <= 1'b0;
            reg_write_q <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
        end else begin
            alu_src_q   <= alu_src_d;
            reg_dst_q   <= reg_dst_d;
            reg_write_q <= reg_write_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    assign ALUSrc     = alu_src_q;
    assign RegDst     = reg_dst_q;
    assign RegWrite   = reg_write_q;
    assign ALUControl = alu_ctrl_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit with a table-driven reference model.
// Build with CONTROLUNIT_EXT_OPS_EN defined to check the extended operations.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic [5:0] Func;
    logic       ALUSrc;
    logic       RegDst;
    logic       RegWrite;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

`ifdef CONTROLUNIT_EXT_OPS_EN
    localparam bit ExtEn = 1'b1;
`else
    localparam bit ExtEn = 1'b0;
`endif

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .Func       (Func),
        .ALUSrc     (ALUSrc),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: instruction tables -> {ALUSrc, RegDst, RegWrite, ALUControl}
    function automatic logic [6:0] model(input logic r, input logic [5:0] op, input logic [5:0] fn);
        logic [5:0] r_fn  [7] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100010, 6'b100111, 6'b101010};
        logic [3:0] r_alu [7] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011,
                                  4'b0110, 4'b1100, 4'b0111};
        bit         r_ext [7] = '{0, 0, 0, 0, 1, 1, 1};
        logic [5:0] i_op  [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
        logic [3:0] i_alu [5] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
        bit         i_ext [5] = '{0, 0, 0, 0, 1};
        if (r) return 7'b0;
        if (op == 6'd0) begin
            for (int i = 0; i < 7; i++)
                if (fn == r_fn[i] && (ExtEn || !r_ext[i])) return {3'b011, r_alu[i]};
        end else begin
            for (int i = 0; i < 5; i++)
                if (op == i_op[i] && (ExtEn || !i_ext[i])) return {3'b101, i_alu[i]};
        end
        return 7'b0;
    endfunction

    function automatic logic [6:0] observed();
        return {ALUSrc, RegDst, RegWrite, ALUControl};
    endfunction

    // Present inputs, clock one edge, settle just past it
    task automatic cycle(input logic r, input logic [5:0] op, input logic [5:0] fn);
        rst = r; Opcode = op; Func = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 6'b001000, 6'b000000);
            checks++;
            if (observed() !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, observed(), 7'b0);
            end
        end
        cycle(1'b0, 6'b001000, 6'b000000);
        exp = {3'b101, 4'b0010};
        checks++;
        if (observed() !== exp || exp !== model(1'b0, 6'b001000, 6'b000000)) begin
            errors++;
            $display("FAIL reset_release_addi: got %b expected %b", observed(), exp);
        end
    endtask

    task automatic test_rtype_func_zero();
        cycle(1'b0, 6'b000000, 6'b000000);
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL rtype_func_zero: got %b expected %b", observed(), 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fns  [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110};
        logic [3:0] alus [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 6'b000000, fns[i]);
            checks++;
            if (observed() !== {3'b011, alus[i]}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, observed(),
                         {3'b011, alus[i]});
            end
        end
    endtask

    task automatic test_func_ignored();
        cycle(1'b0, 6'b001000, 6'b100100);
        checks++;
        if (observed() !== 7'b1010010) begin
            errors++;
            $display("FAIL func_ignored: got %b expected %b", observed(), 7'b1010010);
        end
    endtask

    task automatic test_ext_ops();
        logic [6:0] exp;
        exp = ExtEn ? 7'b0110111 : 7'b0;
        cycle(1'b0, 6'b000000, 6'b101010);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL slt: got %b expected %b", observed(), exp);
        end
        exp = ExtEn ? 7'b1010111 : 7'b0;
        cycle(1'b0, 6'b001010, 6'b000000);
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("FAIL slti: got %b expected %b", observed(), exp);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b0, 6'b000000, 6'b100000);
        cycle(1'b1, 6'b000000, 6'b100000);
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL reset_midstream: got %b expected %b", observed(), 7'b0);
        end
        cycle(1'b0, 6'b111111, 6'b100000);
        checks++;
        if (observed() !== 7'b0) begin
            errors++;
            $display("FAIL illegal_opcode: got %b expected %b", observed(), 7'b0);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
        logic [5:0] fns [8] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110,
                                6'b100010, 6'b100111, 6'b101010, 6'b000000};
        logic       r;
        logic [5:0] op, fn;
        logic [6:0] exp;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 15) == 0);
            op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 7)] : 6'($urandom);
            exp = model(r, op, fn);
            cycle(r, op, fn);
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random[%0d] rst=%b op=%b fn=%b: got %b expected %b",
                         i, r, op, fn, observed(), exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; Opcode = 6'd0; Func = 6'd0;
        test_reset();
        test_rtype_func_zero();
        test_back_to_back();
        test_func_ignored();
        test_ext_ops();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
